positions_to_mask_iterative: RTL

POSITIONS_TO_MASK_ITERATIVE -- requirements
Module: positions_to_mask_iterative

---
 rtl/positions_to_mask_iterative_pkg.sv | 17 +
 rtl/positions_to_mask_iterative_onehot_decoder.sv | 22 ++
 rtl/positions_to_mask_iterative.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/positions_to_mask_iterative_pkg.sv
// Shared package for the positions-to-mask builder.
// Contents:
//   state_t - build FSM states (IDLE, BUILD, DONE_ST)
//   log2up  - index width helper (minimum 1 bit)
package energy_monitor;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUILD   = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  function automatic int unsigned log2up(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/positions_to_mask_iterative_onehot_decoder.sv
// Converts a bit position into a one-hot vector.
// Ports:
//   idx_i    - bit position to decode
//   en_i     - when low the output is all zeros
//   onehot_o - one-hot vector with bit idx_i set
module onehot_decoder #(
  parameter int unsigned N    = 256,
  parameter int unsigned LOGN = (N > 1) ? $clog2(N) : 1
) (
  input  logic [LOGN-1:0] idx_i,
  input  logic            en_i,
  output logic [N-1:0]    onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o = N'(1) << idx_i;
    end
  end

endmodule

// File: rtl/positions_to_mask_iterative.sv
// Rebuilds a bit mask from a list of bit positions, one list entry per clock.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   start_i        - pulse in IDLE to capture the list and begin a build
//   positions_i    - list of positions, entry k at index k
//   valid_i        - per-entry valid bits
//   count_i        - number of entries to consume (clamped to N)
//   mask_o         - mask under construction / final mask
//   set_count_o    - number of distinct bits set in mask_o
//   busy_o, done_o - FSM status; done_o pulses for one cycle at the end
//   dup_o, empty_o, clamp_o - sticky flags, cleared by the next accepted start
module positions_to_mask_iterative
  import energy_monitor::*;
#(
  parameter int unsigned N    = 256,
  parameter int unsigned LOGN = log2up(N)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [N-1:0][LOGN-1:0]   positions_i,
  input  logic [N-1:0]             valid_i,
  input  logic [LOGN:0]            count_i,
  output logic [N-1:0]             mask_o,
  output logic [LOGN:0]            set_count_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     dup_o,
  output logic                     empty_o,
  output logic                     clamp_o
);

  localparam logic [LOGN:0] NCount = (LOGN + 1)'(N);

  state_t                   state_q, state_d;
  logic [N-1:0][LOGN-1:0]   pos_q, pos_d;
  logic [N-1:0]             valid_q, valid_d;
  logic [LOGN:0]            cnt_q, cnt_d;
  logic [LOGN:0]            idx_q, idx_d;
  logic [N-1:0]             mask_q, mask_d;
  logic [LOGN:0]            set_count_q, set_count_d;
  logic                     dup_q, dup_d;
  logic                     empty_q, empty_d;
  logic                     clamp_q, clamp_d;

  logic                     in_range;
  logic [LOGN-1:0]          cur_pos;
  logic                     cur_en;
  logic [N-1:0]             cur_onehot;

  // idx_q only reaches N when in_range is low, so the truncated index is
  // never used to select a live entry.
  always_comb begin
    in_range = (idx_q < cnt_q);
    cur_pos  = pos_q[idx_q[LOGN-1:0]];
    cur_en   = (state_q == BUILD) && in_range && valid_q[idx_q[LOGN-1:0]];
  end

  onehot_decoder #(
    .N    (N),
    .LOGN (LOGN)
  ) u_onehot_decoder (
    .idx_i    (cur_pos),
    .en_i     (cur_en),
    .onehot_o (cur_onehot)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)   state_d = BUILD;
      BUILD:   if (!in_range) state_d = DONE_ST;
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE_ST);
  end

  // Datapath next-state
  always_comb begin
    pos_d       = pos_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    set_count_d = set_count_q;
    dup_d       = dup_q;
    empty_d     = empty_q;
    clamp_d     = clamp_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          pos_d       = positions_i;
          valid_d     = valid_i;
          cnt_d       = (count_i > NCount) ? NCount : count_i;
          idx_d       = '0;
          mask_d      = '0;
          set_count_d = '0;
          dup_d       = 1'b0;
          empty_d     = 1'b0;
          clamp_d     = (count_i > NCount);
        end
      end
      BUILD: begin
        if (in_range) begin
          idx_d = idx_q + (LOGN + 1)'(1);
          if (cur_en) begin
            mask_d = mask_q | cur_onehot;
            // A repeated position leaves set_count alone so it stays <= N.
            if (|(mask_q & cur_onehot)) begin
              dup_d = 1'b1;
            end else begin
              set_count_d = set_count_q + (LOGN + 1)'(1);
            end
          end
        end else begin
          empty_d = (set_count_q == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q       <= '0;
      valid_q     <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      mask_q      <= '0;
      set_count_q <= '0;
      dup_q       <= 1'b0;
      empty_q     <= 1'b0;
      clamp_q     <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      set_count_q <= set_count_d;
      dup_q       <= dup_d;
      empty_q     <= empty_d;
      clamp_q     <= clamp_d;
    end
  end

  assign mask_o      = mask_q;
  assign set_count_o = set_count_q;
  assign dup_o       = dup_q;
  assign empty_o     = empty_q;
  assign clamp_o     = clamp_q;

endmodule
